vga_timing_gen: RTL and testbench

//  Parametrised VGA raster timing generator with built-in pixel clock-enable divider.

---
 rtl/vga_timing_gen.sv | 147 ++++++++++++++
 tb/tb_vga_timing_gen.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator on CLOCK_50 with a built-in pixel clock-enable prescaler.
// Raster outputs change on the pixel edge that moves the counters, delayed by LAT more pixel periods.
module vga_timing_gen #(
   parameter int CLK_DIV  = 2,
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int HS_POL   = 0,
   parameter int VS_POL   = 0,
   parameter int LAT      = 0,
   parameter int CW       = 10
) (
   input  logic          CLOCK_50,
   input  logic          RESET,
   input  logic          ENABLE,
   output logic          PIXEL_CE,
   output logic          Hsync,
   output logic          Vsync,
   output logic          displayON,
   output logic [CW-1:0] Xpixel,
   output logic [CW-1:0] Ypixel,
   output logic          LINE_START,
   output logic          FRAME_START,
   output logic [15:0]   FRAME_COUNT
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int PW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic HS_ON = (HS_POL != 0);
   localparam logic VS_ON = (VS_POL != 0);

   typedef struct packed {
      logic          hs;
      logic          vs;
      logic          de;
      logic [CW-1:0] x;
      logic [CW-1:0] y;
      logic          ls;
      logic          fs;
   } raster_t;

   localparam raster_t IDLE = '{hs: ~HS_ON, vs: ~VS_ON, de: 1'b0, x: '0, y: '0, ls: 1'b0, fs: 1'b0};

   logic [PW-1:0] presc;
   logic          run;
   logic          fresh;
   logic          ce;
   logic [CW-1:0] hcnt;
   logic [CW-1:0] vcnt;
   logic [CW-1:0] hnext;
   logic [CW-1:0] vnext;
   logic          h_act;
   logic          v_act;
   raster_t       dec;
   raster_t       pipe    [0:LAT];
   raster_t       pipe_in [0:LAT];

   // The first enabled edge only arms the prescaler, so the first strobe lands CLK_DIV edges in.
   assign ce = run && (presc == PW'(CLK_DIV - 1));

   always_comb begin
      hnext = hcnt + 1'b1;
      vnext = vcnt;
      if (hcnt == CW'(H_TOTAL - 1)) begin
         hnext = '0;
         vnext = (vcnt == CW'(V_TOTAL - 1)) ? '0 : vcnt + 1'b1;
      end
   end

   always_comb begin
      h_act  = (hnext < CW'(H_ACTIVE));
      v_act  = (vnext < CW'(V_ACTIVE));
      dec    = IDLE;
      dec.de = h_act && v_act;
      dec.x  = (h_act && v_act) ? hnext : '0;
      dec.y  = (h_act && v_act) ? vnext : '0;
      dec.hs = ((hnext >= CW'(H_ACTIVE + H_FP)) &&
                (hnext <= CW'(H_ACTIVE + H_FP + H_SYNC - 1))) ? HS_ON : ~HS_ON;
      dec.vs = ((vnext >= CW'(V_ACTIVE + V_FP)) &&
                (vnext <= CW'(V_ACTIVE + V_FP + V_SYNC - 1))) ? VS_ON : ~VS_ON;
      dec.ls = (hnext == '0);
      dec.fs = (hnext == '0) && (vnext == '0);
   end

   always_comb begin
      pipe_in[0] = dec;
      for (int i = 1; i <= LAT; i++) begin
         pipe_in[i] = pipe[i-1];
      end
   end

   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
         presc       <= '0;
         run         <= 1'b0;
         fresh       <= 1'b0;
         hcnt        <= CW'(H_TOTAL - 1);
         vcnt        <= CW'(V_TOTAL - 1);
         FRAME_COUNT <= '0;
         for (int i = 0; i <= LAT; i++) begin
            pipe[i] <= IDLE;
         end
      end else if (!ENABLE) begin
         presc <= '0;
         run   <= 1'b0;
         fresh <= 1'b0;
         hcnt  <= CW'(H_TOTAL - 1);
         vcnt  <= CW'(V_TOTAL - 1);
         for (int i = 0; i <= LAT; i++) begin
            pipe[i] <= IDLE;
         end
      end else begin
         run   <= 1'b1;
         fresh <= ce;
         if (ce) begin
            presc <= '0;
            hcnt  <= hnext;
            vcnt  <= vnext;
            for (int i = 0; i <= LAT; i++) begin
               pipe[i] <= pipe_in[i];
            end
            if (pipe_in[LAT].fs) begin
               FRAME_COUNT <= FRAME_COUNT + 16'd1;
            end
         end else if (run) begin
            presc <= presc + 1'b1;
         end
      end
   end

   // Strobes are qualified by fresh so they last one clock even when a pixel spans several.
   assign PIXEL_CE    = ce;
   assign Hsync       = pipe[LAT].hs;
   assign Vsync       = pipe[LAT].vs;
   assign displayON   = pipe[LAT].de;
   assign Xpixel      = pipe[LAT].x;
   assign Ypixel      = pipe[LAT].y;
   assign LINE_START  = pipe[LAT].ls && fresh;
   assign FRAME_START = pipe[LAT].fs && fresh;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: a default 640x480 instance and a tiny 12x7 instance with LAT=2, CLK_DIV=1.
module tb_vga_timing_gen;

   logic CLOCK_50 = 1'b0;
   logic clk_en   = 1'b1;
   always #5 if (clk_en) CLOCK_50 = ~CLOCK_50;

   logic        rst_a, en_a, pce_a, hs_a, vs_a, de_a, ls_a, fs_a;
   logic [9:0]  x_a, y_a;
   logic [15:0] fc_a;
   logic        rst_b, en_b, pce_b, hs_b, vs_b, de_b, ls_b, fs_b;
   logic [3:0]  x_b, y_b;
   logic [15:0] fc_b;

   vga_timing_gen u_dut_a (
      .CLOCK_50(CLOCK_50), .RESET(rst_a), .ENABLE(en_a), .PIXEL_CE(pce_a),
      .Hsync(hs_a), .Vsync(vs_a), .displayON(de_a), .Xpixel(x_a), .Ypixel(y_a),
      .LINE_START(ls_a), .FRAME_START(fs_a), .FRAME_COUNT(fc_a)
   );

   vga_timing_gen #(
      .CLK_DIV(1), .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HS_POL(1), .VS_POL(0), .LAT(2), .CW(4)
   ) u_dut_b (
      .CLOCK_50(CLOCK_50), .RESET(rst_b), .ENABLE(en_b), .PIXEL_CE(pce_b),
      .Hsync(hs_b), .Vsync(vs_b), .displayON(de_b), .Xpixel(x_b), .Ypixel(y_b),
      .LINE_START(ls_b), .FRAME_START(fs_b), .FRAME_COUNT(fc_b)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] obs_b();
      return {2'b00, pce_b, hs_b, vs_b, de_b, ls_b, fs_b, x_b, y_b, fc_b};
   endfunction

   // k = pixel index since the first displayed (0,0); negative means still idle.
   function automatic logic [31:0] exp_b(input int k, input logic pce, input logic [15:0] idle_fc);
      int h, v;
      logic de;
      if (k < 0) return {2'b00, pce, 1'b0, 1'b1, 3'b000, 8'h00, idle_fc};
      h  = k % 12;
      v  = (k / 12) % 7;
      de = (h < 8) && (v < 4);
      return {2'b00, pce, (h == 9 || h == 10), (v != 5), de, (h == 0), (h == 0 && v == 0),
              de ? 4'(h) : 4'd0, de ? 4'(v) : 4'd0, 16'(k / 84 + 1)};
   endfunction

   // Called right after the idle->running transition is set up, before the next rising edge.
   task automatic a_startup(input logic [15:0] fc_exp);
      logic [5:0] fl;
      for (int c = 1; c <= 6; c++) begin
         @(negedge CLOCK_50);
         fl = {(c % 2 == 0), 1'b1, 1'b1, (c >= 3), (c == 3), (c == 3)};
         check($sformatf("a_start c%0d flags", c), 32'({pce_a, hs_a, vs_a, de_a, ls_a, fs_a}), 32'(fl));
         check($sformatf("a_start c%0d x", c), 32'(x_a), (c >= 5) ? 32'd1 : 32'd0);
         check($sformatf("a_start c%0d y", c), 32'(y_a), 32'd0);
         check($sformatf("a_start c%0d fc", c), 32'(fc_a), (c >= 3) ? 32'(fc_exp) : 32'(fc_exp - 16'd1));
      end
   endtask

   initial begin
      int ls_cnt, ls_first, hs_low, hs_fall, de_cnt, vs_low;
      logic [9:0] last_x;
      rst_a = 1'b1; en_a = 1'b1;
      rst_b = 1'b1; en_b = 1'b1;
      repeat (3) @(negedge CLOCK_50);
      check("a_reset flags", 32'({pce_a, hs_a, vs_a, de_a, ls_a, fs_a}), 32'(6'b011000));
      check("a_reset xyfc", 32'({x_a, y_a, fc_a[11:0]}), 32'd0);
      check("b_reset", obs_b(), exp_b(-1, 1'b0, 16'd0));

      // Small instance: two full frames plus part of a line, compared every clock.
      rst_b = 1'b0;
      for (int c = 1; c <= 181; c++) begin
         @(negedge CLOCK_50);
         check($sformatf("b_run c%0d", c), obs_b(), exp_b(c - 4, 1'b1, 16'd0));
      end
      // Output is mid-sync here; dropping ENABLE must cut it off with no tail.
      en_b = 1'b0;
      @(negedge CLOCK_50);
      check("b_disable_in_sync", obs_b(), exp_b(-1, 1'b0, 16'd3));

      // Default instance.
      rst_a = 1'b0;
      a_startup(16'd1);
      ls_cnt = 0; ls_first = -1; hs_low = 0; hs_fall = -1; vs_low = 0;
      de_cnt = 4;  // t=0..3 were active and already checked
      last_x = '0;
      for (int t = 4; t <= 8600; t++) begin
         @(negedge CLOCK_50);
         if (ls_a) begin
            ls_cnt++;
            if (ls_first < 0) ls_first = t;
         end
         if (t < 1600) begin
            if (!hs_a) begin
               hs_low++;
               if (hs_fall < 0) hs_fall = t;
            end
            if (de_a) begin
               de_cnt++;
               last_x = x_a;
            end
         end
         if (!vs_a) vs_low++;
      end
      check("a_line_period", 32'(ls_first), 32'd1600);
      check("a_line_count", 32'(ls_cnt), 32'd5);
      check("a_hsync_start", 32'(hs_fall), 32'd1312);
      check("a_hsync_width", 32'(hs_low), 32'd192);
      check("a_active_clocks", 32'(de_cnt), 32'd1280);
      check("a_last_x", 32'(last_x), 32'd639);
      check("a_no_vsync_lines0_5", 32'(vs_low), 32'd0);
      check("a_l5p300 xyde", 32'({de_a, x_a, y_a}), 32'({1'b1, 10'd300, 10'd5}));
      check("a_l5p300 fc", 32'(fc_a), 32'd1);

      en_a = 1'b0;
      @(negedge CLOCK_50);
      check("a_disable flags", 32'({pce_a, hs_a, vs_a, de_a, ls_a, fs_a}), 32'(6'b011000));
      check("a_disable xy", 32'({x_a, y_a}), 32'd0);
      check("a_disable fc", 32'(fc_a), 32'd1);
      repeat (9) @(negedge CLOCK_50);
      check("a_frozen flags", 32'({pce_a, hs_a, vs_a, de_a, ls_a, fs_a}), 32'(6'b011000));
      check("a_frozen fc", 32'(fc_a), 32'd1);
      en_a = 1'b1;
      a_startup(16'd2);

      // Asynchronous reset with the clock parked low.
      clk_en = 1'b0;
      #3 rst_a = 1'b1;
      #1;
      check("a_async flags", 32'({pce_a, hs_a, vs_a, de_a, ls_a, fs_a}), 32'(6'b011000));
      check("a_async xy", 32'({x_a, y_a}), 32'd0);
      check("a_async fc", 32'(fc_a), 32'd0);
      #10 rst_a = 1'b0;
      clk_en = 1'b1;
      a_startup(16'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
